// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, 3-sample majority per bit, valid/ready output.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT buffer; otherwise one holding register.
module uart_rx #(
  parameter int unsigned DIVISOR    = 217,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ftdi_txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] MID0    = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] MID1    = CW'(DIVISOR / 2);
  localparam logic [CW-1:0] MID2    = CW'(DIVISOR / 2 + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_e;

  logic sync1_q, rxs_q, rxs_prev_q;

  // Reset to idle-high so a reset release never looks like a start edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= ftdi_txd;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    smp_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          framing_q;
  logic          mid, maj, push, pop;

  assign mid  = (cnt_q == MID2);
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
  assign push = (state_q == S_STOP) && mid && maj;
  assign pop  = rx_valid && rx_ready;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      smp_q     <= 2'b11;
      bit_q     <= '0;
      shift_q   <= '0;
      framing_q <= 1'b0;
    end else begin
      framing_q <= 1'b0;
      if (state_q inside {S_START, S_DATA, S_STOP}) begin
        cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        if (cnt_q == MID0) smp_q[0] <= rxs_q;
        if (cnt_q == MID1) smp_q[1] <= rxs_q;
      end
      case (state_q)
        S_IDLE: if (rxs_prev_q && !rxs_q) begin
          cnt_q   <= '0;
          state_q <= S_START;
        end
        S_START: if (mid) begin
          if (maj) state_q <= S_IDLE;
          else begin
            state_q <= S_DATA;
            bit_q   <= '0;
          end
        end
        S_DATA: if (mid) begin
          shift_q <= {maj, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= S_STOP;
        end
        // Leave at mid-stop so a start bit right after a one-bit stop is caught.
        S_STOP: if (mid) begin
          if (maj) state_q <= S_IDLE;
          else begin
            framing_q <= 1'b1;
            state_q   <= S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: if (rxs_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign framing_err = framing_q;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic        empty, full, wr_en, overrun_q;

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  // When full, a same-cycle pop frees the head slot that the write lands in.
  assign wr_en    = push && (!full || pop);
  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wp_q      <= '0;
      rp_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (pop)   rp_q <= rp_q + 1'b1;
    end
  end

  assign overrun_err = overrun_q;
`else
  logic [7:0] data_q;
  logic       valid_q, overrun_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && valid_q && !pop;
      if (push && (!valid_q || pop)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign overrun_err = overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVISOR=16; expectations follow UART_RX_FIFO_EN when defined.
module tb_uart_rx;
  localparam int DIV = 16;
`ifdef UART_RX_FIFO_EN
  localparam int FILL = 4;
`else
  localparam int FILL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, framing_err, overrun_err;

  int total = 0, bad = 0;
  int n_rx = 0, n_fe = 0, n_oe = 0;
  logic [7:0] rx_log [0:63];
  int b_rx, b_fe, b_oe;

  uart_rx #(.DIVISOR(DIV), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk), .rst_n(rst_n), .ftdi_txd(line),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .framing_err(framing_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        if (n_rx < 64) rx_log[n_rx] = rx_data;
        n_rx++;
      end
      if (framing_err) n_fe++;
      if (overrun_err) n_oe++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_rx = n_rx; b_fe = n_fe; b_oe = n_oe;
  endtask

  initial begin
    logic [9:0] f;
    idle(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_oerr", overrun_err, 0);
    rst_n = 1'b1;
    idle(20);

    // single byte, consumer always ready
    rx_ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1);
    idle(2 * DIV);
    chk("a5_count", n_rx - b_rx, 1);
    chk("a5_data", rx_log[b_rx], 8'hA5);
    chk("a5_ferr", n_fe - b_fe, 0);
    chk("a5_oerr", n_oe - b_oe, 0);

    // back-to-back frames with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(2 * DIV);
    chk("b2b_valid", rx_valid, 1);
    chk("b2b_head", rx_data, 8'h00);
    rx_ready = 1'b1;
    idle(10);
`ifdef UART_RX_FIFO_EN
    chk("b2b_oerr", n_oe - b_oe, 0);
    chk("b2b_count", n_rx - b_rx, 3);
    chk("b2b_d0", rx_log[b_rx], 8'h00);
    chk("b2b_d1", rx_log[b_rx+1], 8'hFF);
    chk("b2b_d2", rx_log[b_rx+2], 8'h3C);
`else
    chk("b2b_oerr", n_oe - b_oe, 2);
    chk("b2b_count", n_rx - b_rx, 1);
    chk("b2b_d0", rx_log[b_rx], 8'h00);
`endif

    // 4-cycle low glitch must be rejected silently
    snap();
    line = 1'b0;
    idle(4);
    line = 1'b1;
    idle(2 * DIV);
    chk("glitch_count", n_rx - b_rx, 0);
    chk("glitch_ferr", n_fe - b_fe, 0);
    chk("glitch_oerr", n_oe - b_oe, 0);
    send_frame(8'h33, 1'b1);
    idle(2 * DIV);
    chk("after_glitch", rx_log[b_rx], 8'h33);

    // framing error followed by a break, then a good frame
    snap();
    send_frame(8'h55, 1'b0);
    idle(40 * DIV);
    line = 1'b1;
    idle(2 * DIV);
    send_frame(8'h12, 1'b1);
    idle(2 * DIV);
    chk("fe_pulses", n_fe - b_fe, 1);
    chk("fe_count", n_rx - b_rx, 1);
    chk("fe_data", rx_log[b_rx], 8'h12);

    // fill storage, then pop in the exact cycle the next byte is pushed
    rx_ready = 1'b0;
    snap();
    for (int i = 0; i < FILL; i++) send_frame(8'h11 * (i + 1), 1'b1);
    idle(2 * DIV);
    chk("full_head", rx_data, 8'h11);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        // push lands on the 157th edge after the start bit is driven
        repeat (156) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(2 * DIV);
    chk("full_oerr", n_oe - b_oe, 0);
    rx_ready = 1'b1;
    idle(10);
    chk("full_count", n_rx - b_rx, FILL + 1);
    chk("full_first", rx_log[b_rx], 8'h11);
    chk("full_last", rx_log[b_rx + FILL], 8'h5A);

    // reset during data bit 3 of 0x81
    snap();
    f = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 4; i++) begin
      line = f[i];
      idle(DIV);
    end
    line = f[4];
    idle(8);
    rst_n = 1'b0;
    line = 1'b1;
    idle(3);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_ferr", framing_err, 0);
    chk("mid_rst_oerr", overrun_err, 0);
    idle(2);
    rst_n = 1'b1;
    idle(3 * DIV);
    send_frame(8'h7E, 1'b1);
    idle(2 * DIV);
    chk("post_rst_count", n_rx - b_rx, 1);
    chk("post_rst_data", rx_log[b_rx], 8'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the FTDI serial link: deserialises 8N1 frames arriving on `ftdi_txd` and presents bytes to the CPU-side peripheral logic over a valid/ready stream. Counterpart of the existing UART transmitter that drives `ftdi_rxd`. Sits in `top` beside the transmitter, and is driven in simulation by the `top_sim` bench through the same pin.

## Interface
- `DIVISOR`, default 217: `clk_sys` cycles per bit (25 MHz / 115200); legal range 8..65535.
- `FIFO_DEPTH`, default 4: receive FIFO entries (power of two, ≥2); used only with `UART_RX_FIFO_EN`.

- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ftdi_txd`  in  1  serial line from FTDI, asynchronous, idle high.
- `rx_data`  out  8  received byte, valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts; transfer on `rx_valid & rx_ready`.
- `framing_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: completed byte dropped because storage full.

## Operation
- `ftdi_txd` passes a 2-FF synchroniser; both flops reset to 1. All decisions use synchronised value `rxs`.
- Bit timer: counter 0..DIVISOR-1, width clog2(DIVISOR). Mid-bit sample = majority of `rxs` at counts DIVISOR/2-1, DIVISOR/2, DIVISOR/2+1 (integer division).
- FSM states:
  - IDLE: on `rxs` 1→0, clear timer, go START.
  - START: at mid-bit, majority 0 → DATA (timer continues, bit index 0); majority 1 → IDLE (glitch rejected, no error).
  - DATA: each bit period, majority shifted in LSB first; after bit 7 → STOP.
  - STOP: majority 1 → push byte, go IDLE immediately at mid-stop (allows back-to-back frames). Majority 0 → `framing_err` pulse, byte discarded, go WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1 (covers break), then IDLE.
- Push when storage full and no same-cycle pop → byte dropped, `overrun_err` pulse; stored contents unchanged.
- Push and pop in same cycle while full → both succeed, no overrun.
- `rx_data` stable while `rx_valid`=1 and not popped.
- `rx_ready` has no effect when `rx_valid`=0.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=0, `framing_err`=0, `overrun_err`=0, FSM IDLE, FIFO empty.
- Reset assertion mid-frame aborts immediately; partial byte lost; after release, receiver waits for a fresh falling edge (synchroniser at 1 prevents false start).
- Latency: `rx_valid` rises the cycle after the mid-stop majority sample completes (count DIVISOR/2+1 of stop bit), plus 2 synchroniser cycles relative to the line.
- `framing_err`/`overrun_err` asserted exactly one cycle, registered.
- Tolerated baud mismatch: ±3 %.

## Configuration
- `UART_RX_FIFO_EN` defined: FIFO of `FIFO_DEPTH` bytes, first-word-fall-through; `rx_data` driven from head entry; full = `FIFO_DEPTH` entries; pointers wrap modulo depth with an extra wrap bit for full/empty.
- Undefined: single holding register; full ⇔ `rx_valid`=1; `FIFO_DEPTH` ignored. Push/pop, overrun and same-cycle rules identical.

## Test plan
- Bench with DIVISOR=16. Send 0xA5 8N1, `rx_ready`=1 → exactly one transfer, `rx_data`=0xA5, no error pulses.
- Send 0x00, 0xFF, 0x3C back-to-back (stop bit length exactly 1), `rx_ready`=0 until end, FIFO_EN, depth 4 → three bytes read out in order; without FIFO_EN → only 0x00 kept, two `overrun_err` pulses.
- Low glitch of 4 cycles on idle line → no byte, no error, FSM back to IDLE.
- Frame 0x55 with stop bit held low, then line low 40 bit times, then high, then 0x12 → one `framing_err` pulse, 0x55 not delivered, 0x12 delivered.
- Full FIFO (4 bytes), 5th byte completes in same cycle as `rx_ready`=1 pop → no `overrun_err`, 5th byte delivered last.
- `rst_n` low during DATA bit 3 of 0x81, release, send 0x7E → only 0x7E delivered; all outputs 0 during reset.
